// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI master datapath.
//   DATA_WIDTH_DEF : default frame width, also used by the timing generator
//                    wrapper so both sides agree on the word size.
//   state_t        : transfer engine states.
// -----------------------------------------------------------------------------
package spi_pkg;

  localparam int DATA_WIDTH_DEF = 8;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    XFER,
    HOLD,
    DONE
  } state_t;

endpackage

// File: rtl/spi_edge_detect.sv
// -----------------------------------------------------------------------------
// spi_edge_detect
// Classifies transitions of the timing generator's serial clock as leading
// (moving away from the idle level) or trailing (returning to idle).
// Ports:
//   clk     in  system clock
//   reset   in  synchronous active-low reset
//   sclk_in in  generator clk_out
//   cpol    in  SCLK idle level
//   lead    out transition away from idle seen this cycle
//   trail   out transition back to idle seen this cycle
// -----------------------------------------------------------------------------
module spi_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic sclk_in,
  input  logic cpol,
  output logic lead,
  output logic trail
);

  logic sclk_q;

  // Reset to the idle level so no phantom edge appears when reset releases.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sclk_q <= cpol;
    end else begin
      sclk_q <= sclk_in;
    end
  end

  assign lead  = (sclk_in != sclk_q) && (sclk_in != cpol);
  assign trail = (sclk_in != sclk_q) && (sclk_in == cpol);

endmodule

// File: rtl/spi_shift_engine.sv
// -----------------------------------------------------------------------------
// spi_shift_engine
// SPI master transfer engine. Follows the timing generator's SCLK, shifts one
// word out on mosi while assembling one word from miso, drives ss_n and the
// generator enable/clear, and offers a valid/ready word interface to the host.
// Ports:
//   clk, reset           system clock, synchronous active-low reset
//   tx_data/tx_valid     host word offer, accepted when tx_ready is high
//   tx_ready             engine idle and accepting
//   rx_data/rx_valid     received word, rx_valid pulses one cycle on update
//   busy                 frame in progress (SETUP through DONE)
//   cpol/cpha/lsb_first  mode controls, stable while busy
//   sclk_in              generator clk_out
//   tg_en/tg_clr         generator enable / clear
//   ss_n, mosi, miso     SPI bus
// -----------------------------------------------------------------------------
module spi_shift_engine
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int SS_HOLD    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  busy,
  input  logic                  cpol,
  input  logic                  cpha,
  input  logic                  lsb_first,
  input  logic                  sclk_in,
  output logic                  tg_en,
  output logic                  tg_clr,
  output logic                  ss_n,
  output logic                  mosi,
  input  logic                  miso
);

  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam int HW = (SS_HOLD > 1) ? $clog2(SS_HOLD) : 1;

  localparam logic [CW-1:0] CNT_LAST  = CW'(DATA_WIDTH);
  localparam logic [CW-1:0] CNT_PEN   = CW'(DATA_WIDTH - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(SS_HOLD - 1);

  state_t                state;
  logic [DATA_WIDTH-1:0] tx_sh;
  logic [DATA_WIDTH-1:0] rx_sh;
  logic [CW-1:0]         cnt;
  logic [HW-1:0]         hold_cnt;
  logic                  lead;
  logic                  trail;

  // Bit that goes on the wire next, taken from the end selected by bit order.
  function automatic logic first_bit(input logic [DATA_WIDTH-1:0] w,
                                     input logic lsb);
    return lsb ? w[0] : w[DATA_WIDTH-1];
  endfunction

  // Remove the bit just driven so the next one moves into the output position.
  function automatic logic [DATA_WIDTH-1:0] drop_bit(input logic [DATA_WIDTH-1:0] w,
                                                     input logic lsb);
    return lsb ? {1'b0, w[DATA_WIDTH-1:1]} : {w[DATA_WIDTH-2:0], 1'b0};
  endfunction

  // Receive fills from the opposite end to transmit, so after DATA_WIDTH
  // samples the first bit received lands where the first bit sent came from.
  function automatic logic [DATA_WIDTH-1:0] push_bit(input logic [DATA_WIDTH-1:0] w,
                                                     input logic b,
                                                     input logic lsb);
    return lsb ? {b, w[DATA_WIDTH-1:1]} : {w[DATA_WIDTH-2:0], b};
  endfunction

  spi_edge_detect u_edge (
    .clk    (clk),
    .reset  (reset),
    .sclk_in(sclk_in),
    .cpol   (cpol),
    .lead   (lead),
    .trail  (trail)
  );

  // Shift registers carry no reset: each frame loads tx_sh on accept and
  // pushes a full word through rx_sh before it is ever published.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      tx_ready <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      busy     <= 1'b0;
      ss_n     <= 1'b1;
      mosi     <= 1'b0;
      tg_en    <= 1'b0;
      tg_clr   <= 1'b1;
      cnt      <= '0;
      hold_cnt <= '0;
    end else begin
      rx_valid <= 1'b0;
      case (state)
        IDLE: begin
          tx_ready <= 1'b1;
          tg_clr   <= 1'b1;
          tg_en    <= 1'b0;
          ss_n     <= 1'b1;
          mosi     <= 1'b0;
          if (tx_valid && tx_ready) begin
            state    <= SETUP;
            tx_ready <= 1'b0;
            busy     <= 1'b1;
            ss_n     <= 1'b0;
            cnt      <= '0;
            // cpha=0 slaves sample on the first edge, so the first bit must
            // already be on mosi during SETUP.
            if (!cpha) begin
              mosi  <= first_bit(tx_data, lsb_first);
              tx_sh <= drop_bit(tx_data, lsb_first);
            end else begin
              tx_sh <= tx_data;
            end
          end
        end

        SETUP: begin
          state  <= XFER;
          tg_clr <= 1'b0;
          tg_en  <= 1'b1;
        end

        XFER: begin
          if (!cpha) begin
            if (lead) begin
              rx_sh <= push_bit(rx_sh, miso, lsb_first);
              cnt   <= cnt + 1'b1;
            end else if (trail) begin
              // Final trail returns SCLK to idle; nothing more to shift out.
              if (cnt == CNT_LAST) begin
                state    <= HOLD;
                tg_en    <= 1'b0;
                tg_clr   <= 1'b1;
                hold_cnt <= '0;
              end else begin
                mosi  <= first_bit(tx_sh, lsb_first);
                tx_sh <= drop_bit(tx_sh, lsb_first);
              end
            end
          end else begin
            if (lead) begin
              mosi  <= first_bit(tx_sh, lsb_first);
              tx_sh <= drop_bit(tx_sh, lsb_first);
            end else if (trail) begin
              rx_sh <= push_bit(rx_sh, miso, lsb_first);
              cnt   <= cnt + 1'b1;
              if (cnt == CNT_PEN) begin
                state    <= HOLD;
                tg_en    <= 1'b0;
                tg_clr   <= 1'b1;
                hold_cnt <= '0;
              end
            end
          end
        end

        HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            state    <= DONE;
            ss_n     <= 1'b1;
            rx_data  <= rx_sh;
            rx_valid <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end

        DONE: begin
          state    <= IDLE;
          busy     <= 1'b0;
          tx_ready <= 1'b1;
          mosi     <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_shift_engine.sv
// -----------------------------------------------------------------------------
// tb_spi_shift_engine
// Bench for spi_shift_engine with a behavioural SCLK timing generator, a
// selectable miso source (loopback, constant one, or a slave returning a word)
// and a per-frame reference model of the expected serial and parallel results.
// -----------------------------------------------------------------------------
module tb_spi_shift_engine;

  localparam int W   = 8;
  localparam int SSH = 2;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] tx_data = '0;
  logic         tx_valid = 1'b0;
  logic         tx_ready;
  logic [W-1:0] rx_data;
  logic         rx_valid;
  logic         busy;
  logic         cpol = 1'b0;
  logic         cpha = 1'b0;
  logic         lsb_first = 1'b0;
  logic         sclk = 1'b0;
  logic         tg_en;
  logic         tg_clr;
  logic         ss_n;
  logic         mosi;
  logic         miso;

  int vectors = 0;
  int miscompares = 0;

  // generator / miso source state
  int           spr = 1;
  int           div = 0;
  int           src = 0;  // 0 loopback, 1 constant one, 2 slave word
  logic [W-1:0] slv_word = '0;
  int           slv_k = 0;
  bit           adv_pend = 1'b0;
  logic         slv_bit = 1'b0;

  // monitor state
  logic         sclk_seen = 1'b0;
  logic         ss_prev = 1'b1;
  int           lead_cnt = 0, trail_cnt = 0, rxv_cnt = 0;
  int           busy_cyc = 0, en_cyc = 0, fall_cnt = 0;
  int           gap = 1000, min_gap = 1000;
  logic [W-1:0] mosi_seq = '0;
  logic [W-1:0] rx_last = '0;
  logic [W-1:0] rx_q[$];

  always #5 clk = ~clk;

  assign miso = (src == 0) ? mosi : (src == 1) ? 1'b1 : slv_bit;

  spi_shift_engine #(.DATA_WIDTH(W), .SS_HOLD(SSH)) dut (
    .clk      (clk),
    .reset    (reset),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .busy     (busy),
    .cpol     (cpol),
    .cpha     (cpha),
    .lsb_first(lsb_first),
    .sclk_in  (sclk),
    .tg_en    (tg_en),
    .tg_clr   (tg_clr),
    .ss_n     (ss_n),
    .mosi     (mosi),
    .miso     (miso)
  );

  // Timing generator: half-period of spr+1 clk cycles, parked at cpol on clear.
  always @(posedge clk) begin
    if (tg_clr === 1'b1) begin
      sclk <= cpol;
      div  <= 0;
    end else if (tg_en === 1'b1) begin
      if (div == spr) begin
        div  <= 0;
        sclk <= ~sclk;
      end else begin
        div <= div + 1;
      end
    end
  end

  // Bus monitor and slave: sampled on the falling clk edge.
  always @(negedge clk) begin
    logic         chg;
    logic         is_lead;
    logic [W-1:0] tmp;
    chg       = (sclk !== sclk_seen);
    is_lead   = (sclk !== cpol);
    sclk_seen = sclk;
    // slave advances one cycle after a sample edge, once the master has taken it
    if (adv_pend) begin
      slv_k    = slv_k + 1;
      adv_pend = 1'b0;
    end
    if (ss_n !== 1'b0) slv_k = 0;
    if (ss_n === 1'b0 && chg) begin
      if (is_lead) lead_cnt++;
      else trail_cnt++;
      if (is_lead != cpha) begin
        mosi_seq = {mosi_seq[W-2:0], mosi};
        adv_pend = 1'b1;
      end
    end
    tmp     = lsb_first ? (slv_word >> slv_k) : (slv_word << slv_k);
    slv_bit = (slv_k < W) ? (lsb_first ? tmp[0] : tmp[W-1]) : 1'b0;
    if (rx_valid === 1'b1) begin
      rxv_cnt++;
      rx_last = rx_data;
      rx_q.push_back(rx_data);
    end
    if (busy === 1'b1) busy_cyc++;
    if (tg_en === 1'b1) en_cyc++;
    if (ss_n === 1'b1) begin
      gap++;
    end else if (ss_prev === 1'b1) begin
      fall_cnt++;
      if (fall_cnt > 1 && gap < min_gap) min_gap = gap;
      gap = 0;
    end
    ss_prev = ss_n;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    lead_cnt  = 0;
    trail_cnt = 0;
    rxv_cnt   = 0;
    busy_cyc  = 0;
    en_cyc    = 0;
    fall_cnt  = 0;
    gap       = 1000;
    min_gap   = 1000;
    mosi_seq  = '0;
    rx_q.delete();
  endtask

  task automatic set_mode(input logic p, input logic h, input logic l, input int s);
    @(negedge clk);
    cpol      = p;
    cpha      = h;
    lsb_first = l;
    spr       = s;
    repeat (3) @(negedge clk);
  endtask

  task automatic send(input logic [W-1:0] w, output bit ok);
    @(negedge clk);
    tx_data  = w;
    tx_valid = 1'b1;
    ok       = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (tx_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (busy !== 1'b0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(n < 3000), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  // One frame checked against the reference model.
  task automatic frame(input string tag, input logic [W-1:0] w, input int source,
                       input logic [W-1:0] sword);
    bit           ok;
    logic [W-1:0] exp_rx;
    logic [W-1:0] exp_seq;
    src      = source;
    slv_word = sword;
    clear_mon();
    send(w, ok);
    chk({tag, "_accept"}, 32'(ok), 32'd1);
    wait_idle({tag, "_done"});
    if (source == 0) exp_rx = w;
    else if (source == 1) exp_rx = '1;
    else exp_rx = sword;
    if (lsb_first) exp_seq = {<<{w}};
    else exp_seq = w;
    chk({tag, "_rx"}, 32'(rx_last), 32'(exp_rx));
    chk({tag, "_rxv_pulses"}, 32'(rxv_cnt), 32'd1);
    chk({tag, "_leads"}, 32'(lead_cnt), 32'(W));
    chk({tag, "_trails"}, 32'(trail_cnt), 32'(W));
    chk({tag, "_mosi_seq"}, 32'(mosi_seq), 32'(exp_seq));
    chk({tag, "_frame_len"}, 32'(busy_cyc), 32'(en_cyc + SSH + 2));
    chk({tag, "_mosi_idle"}, 32'(mosi), 32'd0);
    chk({tag, "_ss_idle"}, 32'(ss_n), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit           ok;
    int           t;
    logic [15:0]  got;

    // reset values
    reset = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_tx_ready", 32'(tx_ready), 32'd0);
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_rx_data", 32'(rx_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ss_n", 32'(ss_n), 32'd1);
    chk("rst_mosi", 32'(mosi), 32'd0);
    chk("rst_tg_en", 32'(tg_en), 32'd0);
    chk("rst_tg_clr", 32'(tg_clr), 32'd1);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_tx_ready", 32'(tx_ready), 32'd1);

    // mode 0, MSB first, loopback
    set_mode(1'b0, 1'b0, 1'b0, 1);
    frame("m0_loop", 8'hA5, 0, 8'h00);

    // mode 3, LSB first, miso held high
    set_mode(1'b1, 1'b1, 1'b1, 1);
    chk("m3_sclk_idle_pre", 32'(sclk), 32'd1);
    frame("m3_ones", 8'h3C, 1, 8'h00);
    chk("m3_sclk_idle_post", 32'(sclk), 32'd1);

    // mode 1, slave returns a pattern
    set_mode(1'b0, 1'b1, 1'b0, 2);
    frame("m1_slave", 8'hC3, 2, 8'h5A);

    // reset mid-frame after the third leading edge
    set_mode(1'b0, 1'b0, 1'b0, 1);
    src = 0;
    clear_mon();
    send(8'h6E, ok);
    chk("rst_mid_accept", 32'(ok), 32'd1);
    t = 0;
    while (lead_cnt < 3 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("rst_mid_third_lead", 32'(lead_cnt), 32'd3);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_mid_ss_n", 32'(ss_n), 32'd1);
    chk("rst_mid_tg_en", 32'(tg_en), 32'd0);
    chk("rst_mid_tg_clr", 32'(tg_clr), 32'd1);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_mid_mosi", 32'(mosi), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    chk("rst_mid_no_rxv", 32'(rxv_cnt), 32'd0);
    frame("post_rst", 8'h81, 0, 8'h00);

    // back-to-back with tx_valid held high
    src = 0;
    clear_mon();
    @(negedge clk);
    tx_data  = 8'h11;
    tx_valid = 1'b1;
    t = 0;
    while (tx_ready !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    @(posedge clk);
    #1;
    tx_data = 8'h22;
    @(negedge clk);
    t = 0;
    while (tx_ready !== 1'b1 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk("b2b_second_ready", 32'(tx_ready), 32'd1);
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    wait_idle("b2b_done");
    got = '0;
    foreach (rx_q[i]) got = {got[7:0], rx_q[i]};
    chk("b2b_count", 32'(rx_q.size()), 32'd2);
    chk("b2b_words", 32'(got), 32'h1122);
    chk("b2b_ss_gap_ok", 32'(min_gap >= 2), 32'd1);
    chk("b2b_frames", 32'(fall_cnt), 32'd2);

    // a one-cycle offer while busy is dropped
    clear_mon();
    send(8'h44, ok);
    chk("rej_accept", 32'(ok), 32'd1);
    repeat (6) @(negedge clk);
    tx_data  = 8'h33;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    wait_idle("rej_done");
    repeat (20) @(negedge clk);
    got = '0;
    foreach (rx_q[i]) got = {got[7:0], rx_q[i]};
    chk("rej_count", 32'(rx_q.size()), 32'd1);
    chk("rej_word", 32'(got), 32'h0044);
    chk("rej_frames", 32'(fall_cnt), 32'd1);

    // randomized frames across modes, bit orders, dividers and miso sources
    for (int i = 0; i < 12; i++) begin
      set_mode(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), int'($urandom_range(1, 3)));
      frame($sformatf("rand%0d", i), W'($urandom), int'($urandom_range(0, 2)),
            W'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
